// File: rtl/cjbrisc_hmmiop_iop.sv
// cjbrisc_hmmiop_iop -- memory-mapped I/O processor for the CJBRISC core.
// Four output ports and four input ports live at PORT_ADDR 0x3FC-0x3FF.
// The port index is PORT_ADDR[1:0].
//   Clock, Reset           : clock and asynchronous active-high reset
//   LD_OPDR / LD_IPDR      : CU store / load strobes to the I/O space
//   PORT_ADDR, WR_DATA     : strobe address and store data
//   IPDR                   : data returned for the last I/O load
//   OUT_DATA0..3, OUT_VLD  : output port data and valid flags
//   OUT_ACK                : consumer acknowledge for each output port
//   IN_DATA0..3, IN_VLD    : external input data and valid flags
//   IN_ACK, IN_FULL        : capture pulse and holding-full flag for each input port
//   OVR / UNDR             : sticky flags for store-to-busy and load-from-empty
module cjbrisc_hmmiop_iop (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LD_OPDR,
  input  logic       LD_IPDR,
  input  logic [9:0] PORT_ADDR,
  input  logic [7:0] WR_DATA,
  output logic [7:0] IPDR,
  output logic [7:0] OUT_DATA0,
  output logic [7:0] OUT_DATA1,
  output logic [7:0] OUT_DATA2,
  output logic [7:0] OUT_DATA3,
  output logic [3:0] OUT_VLD,
  input  logic [3:0] OUT_ACK,
  input  logic [7:0] IN_DATA0,
  input  logic [7:0] IN_DATA1,
  input  logic [7:0] IN_DATA2,
  input  logic [7:0] IN_DATA3,
  input  logic [3:0] IN_VLD,
  output logic [3:0] IN_ACK,
  output logic [3:0] IN_FULL,
  output logic       OVR,
  output logic       UNDR
);

  typedef enum logic {O_IDLE, O_VALID} out_state_e;
  typedef enum logic {I_EMPTY, I_FULL} in_state_e;

  out_state_e out_st_q [4];
  out_state_e out_st_d [4];
  in_state_e  in_st_q  [4];
  in_state_e  in_st_d  [4];
  logic [7:0] out_data_q [4];
  logic [7:0] out_data_d [4];
  logic [7:0] hold_q [4];
  logic [7:0] hold_d [4];
  logic [7:0] in_data [4];
  logic [3:0] in_ack_q, in_ack_d;
  logic [7:0] ipdr_q, ipdr_d;
  logic       ovr_q, ovr_d;
  logic       undr_q, undr_d;

  logic       io_sel;
  logic [3:0] store_hit, load_hit, capture;

  assign io_sel    = (PORT_ADDR[9:2] == 8'hFF);
  assign store_hit = (LD_OPDR && io_sel) ? (4'b0001 << PORT_ADDR[1:0]) : '0;
  assign load_hit  = (LD_IPDR && io_sel) ? (4'b0001 << PORT_ADDR[1:0]) : '0;

  always_comb begin
    in_data[0] = IN_DATA0;
    in_data[1] = IN_DATA1;
    in_data[2] = IN_DATA2;
    in_data[3] = IN_DATA3;
  end

  always_comb begin
    out_st_d   = out_st_q;
    out_data_d = out_data_q;
    in_st_d    = in_st_q;
    hold_d     = hold_q;
    ipdr_d     = ipdr_q;
    ovr_d      = ovr_q;
    undr_d     = undr_q;
    capture    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      case (out_st_q[i])
        O_IDLE: begin
          if (store_hit[i]) begin
            out_data_d[i] = WR_DATA;
            out_st_d[i]   = O_VALID;
          end
        end
        O_VALID: begin
          // Store coinciding with ack replaces the data and stays valid.
          if (store_hit[i]) begin
            if (OUT_ACK[i]) out_data_d[i] = WR_DATA;
            else            ovr_d         = 1'b1;
          end else if (OUT_ACK[i]) begin
            out_st_d[i] = O_IDLE;
          end
        end
      endcase

      // Capture decided on the current state, so a load that empties a FULL
      // port cannot refill it in the same cycle.
      capture[i] = (in_st_q[i] == I_EMPTY) && IN_VLD[i] && !in_ack_q[i];
      if (capture[i]) begin
        hold_d[i]  = in_data[i];
        in_st_d[i] = I_FULL;
      end
      if (load_hit[i]) begin
        if (in_st_q[i] == I_FULL) begin
          ipdr_d     = hold_q[i];
          in_st_d[i] = I_EMPTY;
        end else begin
          ipdr_d = '0;
          undr_d = 1'b1;
        end
      end
    end
    in_ack_d = capture;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        out_st_q[i]   <= O_IDLE;
        in_st_q[i]    <= I_EMPTY;
        out_data_q[i] <= '0;
        hold_q[i]     <= '0;
      end
      in_ack_q <= '0;
      ipdr_q   <= '0;
      ovr_q    <= 1'b0;
      undr_q   <= 1'b0;
    end else begin
      out_st_q   <= out_st_d;
      in_st_q    <= in_st_d;
      out_data_q <= out_data_d;
      hold_q     <= hold_d;
      in_ack_q   <= in_ack_d;
      ipdr_q     <= ipdr_d;
      ovr_q      <= ovr_d;
      undr_q     <= undr_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      OUT_VLD[i] = (out_st_q[i] == O_VALID);
      IN_FULL[i] = (in_st_q[i] == I_FULL);
    end
  end

  assign OUT_DATA0 = out_data_q[0];
  assign OUT_DATA1 = out_data_q[1];
  assign OUT_DATA2 = out_data_q[2];
  assign OUT_DATA3 = out_data_q[3];
  assign IN_ACK    = in_ack_q;
  assign IPDR      = ipdr_q;
  assign OVR       = ovr_q;
  assign UNDR      = undr_q;

endmodule

// File: doc/cjbrisc_hmmiop_iop.md
CJBRISC_HMMIOP_IOP -- requirements
Module: cjbrisc_hmmiop_iop

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-003 LD_OPDR  in  1  CU store strobe to the I/O space.
REQ-004 LD_IPDR  in  1  CU load strobe from the I/O space.
REQ-005 PORT_ADDR  in  10  address presented in the same cycle as the strobe (MAR D-input).
REQ-006 WR_DATA  in  8  store data from the CU write path.
REQ-007 IPDR  out  8  input-port data register, read by the CU via IB2 select 2'b11.
REQ-008 OUT_DATA0..OUT_DATA3  out  8 each  output-port data registers.
REQ-009 OUT_VLD  out  4  per-port "output data valid".
REQ-010 OUT_ACK  in  4  per-port consumer acknowledge.
REQ-011 IN_DATA0..IN_DATA3  in  8 each  external input data.
REQ-012 IN_VLD  in  4  per-port "input data valid".
REQ-013 IN_ACK  out  4  per-port capture acknowledge, one-cycle pulse.
REQ-014 IN_FULL  out  4  per-port input holding register full.
REQ-015 OVR  out  1  sticky overrun flag: store to a busy port.
REQ-016 UNDR  out  1  sticky underrun flag: load from an empty port.

Function
REQ-017 The I/O space SHALL be PORT_ADDR 0x3FC-0x3FF, with port index p = PORT_ADDR[1:0].
REQ-018 A strobe with PORT_ADDR < 0x3FC SHALL be ignored: no state change.
REQ-019 Output port FSM per p SHALL have states IDLE and VALID; OUT_VLD[p] = (state == VALID).
REQ-020 IDLE, LD_OPDR to p: OUT_DATAp <= WR_DATA; next state VALID; OUT_VLD visible the cycle after the strobe.
REQ-021 VALID, OUT_ACK[p]=1, no store to p: next state IDLE.
REQ-022 VALID, store to p, OUT_ACK[p]=0: data SHALL NOT change; state stays VALID; OVR <= 1.
REQ-023 VALID, store to p and OUT_ACK[p]=1 in the same cycle: OUT_DATAp <= WR_DATA; state stays VALID; OVR unchanged.
REQ-024 OUT_ACK[p] in IDLE SHALL be ignored.
REQ-025 Input port FSM per p SHALL have states EMPTY and FULL; IN_FULL[p] = (state == FULL).
REQ-026 Capture occurs when the port is EMPTY, IN_VLD[p]=1 and IN_ACK[p]=0. On capture: holding[p] <= IN_DATAp; state FULL; IN_ACK[p]=1 for exactly the next cycle.
REQ-027 LD_IPDR to p in FULL: IPDR <= holding[p]; state EMPTY. A new capture SHALL NOT occur in the same cycle; the earliest capture is the following cycle.
REQ-028 LD_IPDR to p in EMPTY: IPDR <= 0x00 and UNDR <= 1. A capture in that same cycle SHALL still proceed.
REQ-029 LD_IPDR with PORT_ADDR < 0x3FC: IPDR holds its value.
REQ-030 LD_OPDR and LD_IPDR asserted together SHALL both be honoured independently at the same PORT_ADDR.
REQ-031 The four ports SHALL operate independently and concurrently.
REQ-032 OVR and UNDR SHALL clear only on Reset.

Reset
REQ-033 Reset SHALL set: IPDR = 0x00; all OUT_DATAp = 0x00; OUT_VLD = 0; IN_ACK = 0; IN_FULL = 0; all holding registers = 0x00; OVR = 0; UNDR = 0; all FSMs to IDLE/EMPTY.
REQ-034 Reset asserted mid-handshake SHALL abort it: OUT_VLD and IN_ACK drop asynchronously, and pending data is discarded.
REQ-035 After Reset deasserts, the first strobe SHALL be honoured on the next rising edge.

Verification
REQ-036 Store to 0x3FD with WR_DATA=0xA5 -> next cycle OUT_DATA1=0xA5, OUT_VLD=4'b0010; OUT_ACK[1] for one cycle -> OUT_VLD=0.
REQ-037 Store 0x11 to 0x3FC, then store 0x22 to 0x3FC with no ack -> OUT_DATA0 stays 0x11, OVR=1; repeat with OUT_ACK[0]=1 in the store cycle -> OUT_DATA0=0x22, OVR unchanged.
REQ-038 IN_VLD[3]=1 with IN_DATA3=0x5C -> IN_FULL[3]=1 and a single-cycle IN_ACK[3]; LD_IPDR at 0x3FF -> IPDR=0x5C, IN_FULL[3]=0.
REQ-039 LD_IPDR at 0x3FE with port 2 EMPTY -> IPDR=0x00, UNDR=1; LD_IPDR at 0x100 -> IPDR unchanged, no flag change.
REQ-040 Port 2 FULL, LD_IPDR at 0x3FE while IN_VLD[2]=1 -> no capture that cycle; capture and IN_ACK[2] on the following cycle.
REQ-041 Reset asserted between clock edges while OUT_VLD[0]=1 and IN_FULL[1]=1 -> all outputs reach reset values before the next edge.
